// File: rtl/alu_pipe.sv
// Pipelined ALU with single-cycle ops and an iterative shift-add multiplier.
// Valid/ready on both sides; result and flags are fully registered.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [3:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carryout,
    output logic             overflow,
    output logic             negative,
    output logic             illegal
);

    localparam int            CW   = $clog2(WIDTH);
    localparam int            MSB  = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_sum;
    logic             w_sub;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_o;
    logic             w_ill;

    assign in_ready   = !reset && (r_state == S_IDLE)
                        && (!out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (command == 4'd12);
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == LAST);
    assign w_mul_sum  = r_acc + (r_mb[0] ? r_ma : '0);

    // SUB reuses the adder as A + ~B + 1
    assign w_sub = (command == 4'd1);
    assign w_bop = w_sub ? ~operandB : operandB;
    assign w_sum = {1'b0, operandA} + {1'b0, w_bop}
                   + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf = (operandA[MSB] == w_bop[MSB])
                   && (w_sum[MSB] != operandA[MSB]);
    assign w_sh  = operandB[SHW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:  if (w_mul_done) w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_o   = 1'b0;
        w_ill = 1'b0;
        case (command)
            4'd0, 4'd1: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_o   = w_ovf;
            end
            4'd2:  w_res = operandA ^ operandB;
            4'd3:  w_res = {{(WIDTH-1){1'b0}},
                           $signed(operandA) < $signed(operandB)};
            4'd4:  w_res = operandA & operandB;
            4'd5:  w_res = ~(operandA & operandB);
            4'd6:  w_res = ~(operandA | operandB);
            4'd7:  w_res = operandA | operandB;
            4'd8:  w_res = {{(WIDTH-1){1'b0}}, operandA < operandB};
            4'd9:  w_res = operandA << w_sh;
            4'd10: w_res = operandA >> w_sh;
            4'd11: w_res = $signed(operandA) >>> w_sh;
            4'd12: w_res = '0;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ma      <= '0;
            r_mb      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (w_accept && w_is_mul) begin
                r_ma  <= operandA;
                r_mb  <= operandB;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == S_MUL) begin
                r_ma  <= r_ma << 1;
                r_mb  <= r_mb >> 1;
                r_acc <= w_mul_sum;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept && !w_is_mul) begin
                out_valid <= 1'b1;
                result    <= w_res;
                zero      <= (w_res == '0);
                negative  <= w_res[MSB];
                carryout  <= w_c;
                overflow  <= w_o;
                illegal   <= w_ill;
            end else if (w_mul_done) begin
                out_valid <= 1'b1;
                result    <= w_mul_sum;
                zero      <= (w_mul_sum == '0);
                negative  <= w_mul_sum[MSB];
                carryout  <= 1'b0;
                overflow  <= 1'b0;
                illegal   <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe at WIDTH=32.
// Expected results come from a behavioural model in the bench.
module tb_alu_pipe;

    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [3:0]   command;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carryout;
    logic         overflow;
    logic         negative;
    logic         illegal;

    typedef struct packed {
        logic [W-1:0] res;
        logic [4:0]   fl;
    } exp_t;

    exp_t q[$];
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .operandA(operandA), .operandB(operandB),
        .command(command),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carryout(carryout),
        .overflow(overflow), .negative(negative),
        .illegal(illegal)
    );

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic [3:0] cmd);
        exp_t        e;
        logic [W-1:0] r;
        logic        c;
        logic        o;
        logic        il;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 1'b0; o = 1'b0; il = 1'b0;
        case (cmd)
            4'd0: begin
                p = 64'(a) + 64'(b);
                r = p[W-1:0];
                c = p[W];
                s = sa + sb;
                o = (s > MAXS) || (s < MINS);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                o = (s > MAXS) || (s < MINS);
            end
            4'd2:  r = a ^ b;
            4'd3:  r = (sa < sb) ? 1 : 0;
            4'd4:  r = a & b;
            4'd5:  r = ~(a & b);
            4'd6:  r = ~(a | b);
            4'd7:  r = a | b;
            4'd8:  r = (a < b) ? 1 : 0;
            4'd9:  r = a << b[4:0];
            4'd10: r = a >> b[4:0];
            4'd11: r = W'(sa >>> b[4:0]);
            4'd12: begin
                p = 64'(a) * 64'(b);
                r = p[W-1:0];
            end
            default: il = 1'b1;
        endcase
        e.res = r;
        e.fl  = {r == '0, c, o, r[W-1], il};
        return e;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        exp_t e;
        #1;
        if (reset) q.delete();
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $error("FAIL sb_underflow observed=%h expected=none",
                       result);
            end else begin
                e = q.pop_front();
                chk("sb_res", result, e.res);
                chk("sb_flags",
                    {zero, carryout, overflow, negative, illegal},
                    e.fl);
            end
        end
        if (in_valid && in_ready)
            q.push_back(model(operandA, operandB, command));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
        in_valid = 1'b1;
        command  = cmd;
        operandA = a;
        operandB = b;
    endtask

    logic [3:0]   t_cmd [16] = '{
        4'd0, 4'd0, 4'd1, 4'd3, 4'd8, 4'd11, 4'd10, 4'd9,
        4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd14, 4'd9, 4'd1};
    logic [W-1:0] t_a [16] = '{
        32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF,
        32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h12345678,
        32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
        32'hF0F0F0F0, 32'h00001234, 32'h00000001, 32'h80000000};
    logic [W-1:0] t_b [16] = '{
        32'h1, 32'h1, 32'd7, 32'h1,
        32'h1, 32'h24, 32'h24, 32'h20,
        32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
        32'hFF00FF00, 32'h00005678, 32'h1F, 32'h1};
    logic [W-1:0] t_r [16] = '{
        32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h1,
        32'h0, 32'hF8000000, 32'h08000000, 32'h12345678,
        32'h0FF00FF0, 32'hF000F000, 32'h0FFF0FFF, 32'h000F000F,
        32'hFFF0FFF0, 32'h0, 32'h80000000, 32'h7FFFFFFF};

    logic [W-1:0] held;
    logic         seen;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        command   = '0;
        operandA  = '0;
        operandB  = '0;
        repeat (3) cyc();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags",
            {zero, carryout, overflow, negative, illegal}, 0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++) begin
            drive(t_cmd[i], t_a[i], t_b[i]);
            cyc();
            chk($sformatf("tbl%0d", i), result, t_r[i]);
        end
        chk("add_wrap_c_last", {zero, illegal}, 2'b00);
        in_valid = 1'b0;
        cyc();
        chk("drain_idle", out_valid, 0);

        drive(4'd14, 32'hDEAD, 32'hBEEF);
        cyc();
        in_valid = 1'b0;
        chk("rsv_flags",
            {result, zero, carryout, overflow, illegal},
            {32'h0, 4'b1001});
        cyc();

        drive(4'd12, 32'h00010001, 32'h00010001);
        cyc();
        drive(4'd0, 32'h1, 32'h1);
        for (int i = 1; i <= 32; i++) begin
            chk("mul_busy_rdy", in_ready, 0);
            chk("mul_busy_v", out_valid, 0);
            cyc();
        end
        in_valid = 1'b0;
        chk("mul_valid", out_valid, 1);
        chk("mul_res", result, 32'h00020001);
        cyc();

        drive(4'd12, 32'h3, 32'h5);
        cyc();
        in_valid = 1'b0;
        repeat (9) cyc();
        reset = 1'b1;
        cyc();
        chk("abort_rdy0", in_ready, 0);
        cyc();
        chk("abort_rdy1", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("abort_post_rdy", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            cyc();
        end
        chk("abort_no_valid", seen, 0);

        for (int i = 0; i < 4; i++) begin
            drive(4'd0, 32'h100 * (i + 1), 32'h11);
            cyc();
            chk("stream_v", out_valid, 1);
            chk("stream_rdy", in_ready, 1);
        end
        out_ready = 1'b0;
        drive(4'd0, 32'h1000, 32'h2345);
        #1;
        held = result;
        chk("stall_held", held, 32'h411);
        chk("stall_rdy", in_ready, 0);
        repeat (3) begin
            cyc();
            chk("stall_res", result, held);
            chk("stall_v", out_valid, 1);
            chk("stall_rdy_c", in_ready, 0);
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("swap_v", out_valid, 1);
        chk("swap_res", result, 32'h3345);
        cyc();
        chk("clear_v", out_valid, 0);
        chk("keep_res", result, 32'h3345);
        chk("sb_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), number of operandB LSBs used as shift amount.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts request this cycle; transfer when in_valid && in_ready.
REQ-007 operandA  input  WIDTH  first operand.
REQ-008 operandB  input  WIDTH  second operand / shift amount.
REQ-009 command  input  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT (signed), 4 AND, 5 NAND, 6 NOR, 7 OR, 8 SLTU, 9 SLL, 10 SRL, 11 SRA, 12 MUL, 13-15 reserved.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result; transfer when out_valid && out_ready.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero, carryout, overflow, negative, illegal  output  1 each  registered flags.

Function
REQ-014 FSM states IDLE, MUL; all outputs registered except in_ready.
REQ-015 in_ready SHALL = !reset && state==IDLE && (!out_valid || out_ready).
REQ-016 Commands 0-11 and 13-15: latency 1; result/flags loaded and out_valid=1 at the edge after acceptance; back-to-back acceptance every cycle when out_ready=1.
REQ-017 ADD/SUB: WIDTH-bit wrap; SUB computed as A + ~B + 1; carryout = carry out of MSB (SUB: 1 means no borrow); overflow = signed overflow.
REQ-018 carryout and overflow SHALL be 0 for all commands other than ADD/SUB.
REQ-019 SLT: result = 1 if signed A < signed B else 0; SLTU unsigned compare; upper bits 0.
REQ-020 SLL/SRL/SRA: shift A by operandB[SHW-1:0]; SRA sign-fills; shift of 0 returns A.
REQ-021 MUL: on acceptance enter MUL, iterative shift-add over WIDTH cycles; result = low WIDTH bits of A*B (unsigned); out_valid rises exactly WIDTH cycles after the acceptance edge, then return to IDLE.
REQ-022 In MUL state in_ready=0; inputs ignored; operands latched at acceptance.
REQ-023 Reserved commands 13-15: result 0, zero=1, illegal=1; illegal=0 for all other commands.
REQ-024 zero = (result == 0); negative = result[WIDTH-1]; computed from the final result for every command.
REQ-025 While out_valid && !out_ready, result and all flags SHALL hold stable; no new acceptance.
REQ-026 On out_valid && out_ready with no simultaneous acceptance or MUL completion, out_valid clears next edge; result/flags keep last value.
REQ-027 Simultaneous output transfer and input acceptance: new result replaces old, out_valid stays 1.

Reset
REQ-028 While reset=1 at an edge: state=IDLE, out_valid=0, result=0, all flags 0, MUL accumulator/counter cleared.
REQ-029 Reset during MUL aborts the operation; no result is produced for it.
REQ-030 in_ready=0 during any cycle reset is high; first acceptance possible the first cycle after reset deasserts.

Verification
REQ-031 WIDTH=32: ADD A=0xFFFFFFFF, B=1 -> result 0, zero=1, carryout=1, overflow=0; ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1, negative=1.
REQ-032 SUB 5-7 -> 0xFFFFFFFE, carryout=0, negative=1; SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0.
REQ-033 SRA A=0x80000000, B=0x24 (shift 4) -> 0xF8000000; SRL same -> 0x08000000; SLL shift 0 -> A.
REQ-034 MUL 0x0001_0001 * 0x0001_0001 -> 0x00020001, out_valid exactly 32 cycles after acceptance, in_ready=0 throughout; reset asserted at cycle 10 -> out_valid never rises, in_ready=1 after reset drops.
REQ-035 Stream 4 ADDs with out_ready=1 -> 4 results on consecutive cycles; then hold out_ready=0 for 3 cycles -> result stable, in_ready=0, no requests lost.
REQ-036 command=14 -> result 0, zero=1, illegal=1, carryout=0, overflow=0.
